// File: rtl/gelato_fetch_skd_pkg.sv
// Shared types and helpers for the fetch scheduler slice.
// `WARP_NUM sets the warp count (power of two, >= 2), default 8.
`ifndef WARP_NUM
`define WARP_NUM 8
`endif

package gelato_fetch_skd_pkg;

  localparam int WARP_NUM    = `WARP_NUM;
  localparam int WARP_BITS   = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1;
  localparam int ADDR_WIDTH  = 32;
  localparam int SPLIT_WIDTH = 4;
  localparam int INST_BITS   = 32;

  typedef logic [WARP_BITS-1:0]   warp_num_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [SPLIT_WIDTH-1:0] split_table_num_t;
  typedef logic [INST_BITS-1:0]   inst_t;

  typedef struct packed {
    addr_t     pc;
    warp_num_t warp;
    logic      epoch;
  } fetch_req_t;

  // One-hot warp mask, all zero when en is low.
  function automatic logic [WARP_NUM-1:0] warp_onehot(input logic en, input warp_num_t w);
    logic [WARP_NUM-1:0] v;
    v = '0;
    if (en) begin
      v[w] = 1'b1;
    end else begin
      v = '0;
    end
    return v;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    if (en && (c != 32'hFFFF_FFFF)) begin
      return c + 32'd1;
    end else begin
      return c;
    end
  endfunction

endpackage

// File: rtl/gelato_pctable_fetchskd_if.sv
// PC table -> fetch scheduler bundle: per-warp pc state plus warp activation.
interface gelato_pctable_fetchskd_if;
  import gelato_fetch_skd_pkg::*;

  logic [WARP_NUM-1:0] valid;
  addr_t               pc              [WARP_NUM];
  split_table_num_t    split_table_num [WARP_NUM];
  logic                activate_valid;
  warp_num_t           activate_warp_num;

  modport master (
    output valid, pc, split_table_num, activate_valid, activate_warp_num
  );

  modport slave (
    input valid, pc, split_table_num, activate_valid, activate_warp_num
  );
endinterface

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
// The pointer itself lives in the parent.
module gelato_rr_arbiter
  import gelato_fetch_skd_pkg::*;
#(
  parameter int WARPS = WARP_NUM
) (
  input  logic [WARPS-1:0] req,
  input  warp_num_t        ptr,
  output logic             grant_valid,
  output warp_num_t        grant
);

  warp_num_t idx_s;

  // Scan ptr+1 .. ptr+WARPS; power-of-two width makes the wrap free.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx_s       = '0;
    for (int i = 1; i <= WARPS; i++) begin
      idx_s = ptr + warp_num_t'(i);
      if (!grant_valid && req[idx_s]) begin
        grant_valid = 1'b1;
        grant       = idx_s;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/gelato_fetch_skd.sv
// Fetch scheduler: picks an eligible warp round-robin, issues one I-cache
// fetch per warp, and forwards epoch-matched responses to decode.
// Optional: define GELATO_FETCH_PERF_EN for saturating perf counters.
module gelato_fetch_skd
  import gelato_fetch_skd_pkg::*;
#(
  parameter int WARPS      = WARP_NUM,
  parameter int INST_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  gelato_pctable_fetchskd_if.slave  pctable,
  output logic                      req_valid,
  input  logic                      req_ready,
  output addr_t                     req_pc,
  output warp_num_t                 req_warp,
  output logic                      req_epoch,
  input  logic                      rsp_valid,
  output logic                      rsp_ready,
  input  warp_num_t                 rsp_warp,
  input  logic                      rsp_epoch,
  input  logic [INST_WIDTH-1:0]     rsp_inst,
  input  logic                      flush_valid,
  input  warp_num_t                 flush_warp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output warp_num_t                 out_warp,
  output addr_t                     out_pc,
  output split_table_num_t          out_split,
  output logic [INST_WIDTH-1:0]     out_inst
`ifdef GELATO_FETCH_PERF_EN
  ,
  output logic [31:0]               perf_issue_cnt,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_drop_cnt
`endif
);

  logic [WARPS-1:0]        active_r;
  logic [WARPS-1:0]        pending_r;
  logic [WARPS-1:0]        epoch_r;
  warp_num_t               ptr_r;
  logic                    req_valid_r;
  fetch_req_t              req_r;
  addr_t                   slot_pc_r    [WARPS];
  split_table_num_t        slot_split_r [WARPS];
  logic                    out_valid_r;
  warp_num_t               out_warp_r;
  addr_t                   out_pc_r;
  split_table_num_t        out_split_r;
  logic [INST_WIDTH-1:0]   out_inst_r;

  logic [WARPS-1:0]        flush_mask_s;
  logic [WARPS-1:0]        act_mask_s;
  logic [WARPS-1:0]        eligible_s;
  logic [WARPS-1:0]        grant_mask_s;
  logic [WARPS-1:0]        rsp_mask_s;
  logic                    grant_valid_s;
  warp_num_t               grant_s;
  logic                    can_issue_s;
  logic                    withdraw_s;
  logic                    grant_fire_s;
  logic                    rsp_fire_s;
  logic                    rsp_hit_s;

  // A flushed warp is masked out of arbitration so the flush wins the cycle.
  assign flush_mask_s = warp_onehot(flush_valid, flush_warp);
  assign act_mask_s   = warp_onehot(pctable.activate_valid, pctable.activate_warp_num);
  assign eligible_s   = active_r & pctable.valid & ~pending_r & ~flush_mask_s;

  gelato_rr_arbiter #(.WARPS(WARPS)) u_arb (
    .req         (eligible_s),
    .ptr         (ptr_r),
    .grant_valid (grant_valid_s),
    .grant       (grant_s)
  );

  // A pending request may only be replaced once it is accepted; a flush of
  // its own warp is the single case where it is pulled back.
  assign can_issue_s  = !req_valid_r || req_ready;
  assign withdraw_s   = req_valid_r && !req_ready && flush_valid && (flush_warp == req_r.warp);
  assign grant_fire_s = can_issue_s && grant_valid_s;
  assign grant_mask_s = warp_onehot(grant_fire_s, grant_s);

  // Responses are taken whenever the output register is free or draining;
  // only a pending, epoch-matched, unflushed warp produces an instruction.
  assign rsp_ready  = !out_valid_r || out_ready;
  assign rsp_fire_s = rsp_valid && rsp_ready;
  assign rsp_hit_s  = rsp_fire_s && pending_r[rsp_warp] && (rsp_epoch == epoch_r[rsp_warp])
                      && !flush_mask_s[rsp_warp];
  assign rsp_mask_s = warp_onehot(rsp_hit_s, rsp_warp);

  assign req_valid = req_valid_r;
  assign req_pc    = req_r.pc;
  assign req_warp  = req_r.warp;
  assign req_epoch = req_r.epoch;
  assign out_valid = out_valid_r;
  assign out_warp  = out_warp_r;
  assign out_pc    = out_pc_r;
  assign out_split = out_split_r;
  assign out_inst  = out_inst_r;

  // Per-warp state: activation beats a same-cycle grant, flush beats everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_r  <= '0;
      pending_r <= '0;
      epoch_r   <= '0;
    end else begin
      active_r  <= ((active_r & ~grant_mask_s) | act_mask_s) & ~flush_mask_s;
      pending_r <= (pending_r | grant_mask_s) & ~rsp_mask_s & ~flush_mask_s;
      epoch_r   <= epoch_r ^ flush_mask_s;
    end
  end

  // Request register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_valid_r <= 1'b0;
      req_r       <= '0;
      ptr_r       <= warp_num_t'(WARPS - 1);
    end else if (withdraw_s) begin
      req_valid_r <= 1'b0;
    end else if (can_issue_s) begin
      req_valid_r <= grant_valid_s;
      if (grant_valid_s) begin
        req_r <= '{pc: pctable.pc[grant_s], warp: grant_s, epoch: epoch_r[grant_s]};
        ptr_r <= grant_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end else begin
      req_valid_r <= req_valid_r;
    end
  end

  // Pending slots keep pc/split of the in-flight fetch for tagging its response.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WARPS; w++) begin
      if (!rst_n) begin
        slot_pc_r[w]    <= '0;
        slot_split_r[w] <= '0;
      end else if (grant_mask_s[w]) begin
        slot_pc_r[w]    <= pctable.pc[w];
        slot_split_r[w] <= pctable.split_table_num[w];
      end else begin
        slot_pc_r[w]    <= slot_pc_r[w];
        slot_split_r[w] <= slot_split_r[w];
      end
    end
  end

  // Decode-facing register: loads on a matching response, clears on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_warp_r  <= '0;
      out_pc_r    <= '0;
      out_split_r <= '0;
      out_inst_r  <= '0;
    end else if (rsp_hit_s) begin
      out_valid_r <= 1'b1;
      out_warp_r  <= rsp_warp;
      out_pc_r    <= slot_pc_r[rsp_warp];
      out_split_r <= slot_split_r[rsp_warp];
      out_inst_r  <= rsp_inst;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef GELATO_FETCH_PERF_EN
  logic rsp_drop_s;
  assign rsp_drop_s = rsp_fire_s && !rsp_hit_s;

  // Saturating event counters for issues, stalls and dropped responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issue_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
      perf_drop_cnt  <= 32'd0;
    end else begin
      perf_issue_cnt <= sat_inc(perf_issue_cnt, req_valid_r && req_ready);
      perf_stall_cnt <= sat_inc(perf_stall_cnt, req_valid_r && !req_ready);
      perf_drop_cnt  <= sat_inc(perf_drop_cnt, rsp_drop_s);
    end
  end
`endif

endmodule

// File: tb/tb_gelato_fetch_skd.sv
// Bench for gelato_fetch_skd: directed scenarios then randomized traffic,
// all checked against a per-warp behavioural model and an I-cache queue.
module tb_gelato_fetch_skd;
  import gelato_fetch_skd_pkg::*;

  localparam int W = WARP_NUM;

  logic              clk;
  logic              rst_n;
  logic              req_valid, req_ready, req_epoch;
  addr_t             req_pc;
  warp_num_t         req_warp;
  logic              rsp_valid, rsp_ready, rsp_epoch;
  warp_num_t         rsp_warp;
  logic [31:0]       rsp_inst;
  logic              flush_valid;
  warp_num_t         flush_warp;
  logic              out_valid, out_ready;
  warp_num_t         out_warp;
  addr_t             out_pc;
  split_table_num_t  out_split;
  logic [31:0]       out_inst;
`ifdef GELATO_FETCH_PERF_EN
  logic [31:0]       perf_issue_cnt, perf_stall_cnt, perf_drop_cnt;
`endif

  gelato_pctable_fetchskd_if pif ();

  gelato_fetch_skd #(.WARPS(W), .INST_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .pctable(pif),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .req_warp(req_warp), .req_epoch(req_epoch),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_warp(rsp_warp),
    .rsp_epoch(rsp_epoch), .rsp_inst(rsp_inst),
    .flush_valid(flush_valid), .flush_warp(flush_warp),
    .out_valid(out_valid), .out_ready(out_ready), .out_warp(out_warp),
    .out_pc(out_pc), .out_split(out_split), .out_inst(out_inst)
`ifdef GELATO_FETCH_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_active [W];
  bit          m_pending[W];
  bit          m_epoch  [W];
  logic [31:0] m_slot_pc[W];
  logic [3:0]  m_slot_sp[W];
  int          m_ptr;
  bit          m_req_valid;
  int          m_req_warp;
  logic [31:0] m_req_pc;
  bit          m_req_epoch;
  bit          m_out_valid;
  int          m_out_warp;
  logic [31:0] m_out_pc;
  logic [3:0]  m_out_sp;
  logic [31:0] m_out_inst;
  int          m_issue, m_stall, m_drop;

  typedef struct { int warp; bit epoch; } ent_t;
  ent_t icq[$];
  bit   rsp_from_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    pif.activate_valid = 1'b0;
    rsp_valid   = 1'b0;
    rsp_from_q  = 1'b0;
    flush_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int w = 0; w < W; w++) begin
      m_active[w] = 0; m_pending[w] = 0; m_epoch[w] = 0;
      m_slot_pc[w] = '0; m_slot_sp[w] = '0;
    end
    m_ptr = W - 1;
    m_req_valid = 0; m_req_warp = 0; m_req_pc = '0; m_req_epoch = 0;
    m_out_valid = 0; m_out_warp = 0; m_out_pc = '0; m_out_sp = '0; m_out_inst = '0;
    m_issue = 0; m_stall = 0; m_drop = 0;
    icq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    req_ready = 1'b1;
    out_ready = 1'b1;
    rsp_warp = '0; rsp_epoch = 1'b0; rsp_inst = '0; flush_warp = '0;
    pif.activate_warp_num = '0;
    for (int w = 0; w < W; w++) begin
      pif.valid[w] = 1'b0;
      pif.pc[w] = 32'h1000 + 32'(w * 16);
      pif.split_table_num[w] = 4'(w);
    end
    @(posedge clk); @(posedge clk); #1;
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_pc",    64'(req_pc),    64'd0);
    check("rst_req_warp",  64'(req_warp),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc",    64'(out_pc),    64'd0);
    check("rst_out_inst",  64'(out_inst),  64'd0);
    check("rst_rsp_ready", 64'(rsp_ready), 64'd1);
`ifdef GELATO_FETCH_PERF_EN
    check("rst_perf_issue", 64'(perf_issue_cnt), 64'd0);
    check("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
    check("rst_perf_drop",  64'(perf_drop_cnt),  64'd0);
`endif
    rst_n = 1'b1;
    model_reset();
  endtask

  // Compare outputs with the model, advance the model one clock, then clock.
  task automatic step();
    bit rr, fire, hit, can_issue, withdraw, found, fl_hit;
    int g, w;
    #1;
    check("req_valid", 64'(req_valid), 64'(m_req_valid));
    if (m_req_valid) begin
      check("req_pc",    64'(req_pc),    64'(m_req_pc));
      check("req_warp",  64'(req_warp),  64'(m_req_warp));
      check("req_epoch", 64'(req_epoch), 64'(m_req_epoch));
    end
    rr = !m_out_valid || out_ready;
    check("rsp_ready", 64'(rsp_ready), 64'(rr));
    check("out_valid", 64'(out_valid), 64'(m_out_valid));
    if (m_out_valid) begin
      check("out_warp",  64'(out_warp),  64'(m_out_warp));
      check("out_pc",    64'(out_pc),    64'(m_out_pc));
      check("out_split", 64'(out_split), 64'(m_out_sp));
      check("out_inst",  64'(out_inst),  64'(m_out_inst));
    end
`ifdef GELATO_FETCH_PERF_EN
    check("perf_issue", 64'(perf_issue_cnt), 64'(m_issue));
    check("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
    check("perf_drop",  64'(perf_drop_cnt),  64'(m_drop));
`endif
    fire   = rsp_valid && rr;
    fl_hit = flush_valid && (flush_warp == rsp_warp);
    hit    = fire && m_pending[rsp_warp] && (rsp_epoch == m_epoch[rsp_warp]) && !fl_hit;
    if (m_req_valid && req_ready) begin
      m_issue++;
      icq.push_back('{warp: m_req_warp, epoch: m_req_epoch});
    end
    if (m_req_valid && !req_ready) m_stall++;
    if (fire && !hit) m_drop++;
    if (fire && rsp_from_q) void'(icq.pop_front());
    if (hit) begin
      m_out_valid = 1; m_out_warp = int'(rsp_warp);
      m_out_pc = m_slot_pc[rsp_warp]; m_out_sp = m_slot_sp[rsp_warp]; m_out_inst = rsp_inst;
    end else if (out_ready) begin
      m_out_valid = 0;
    end
    can_issue = !m_req_valid || req_ready;
    withdraw  = m_req_valid && !req_ready && flush_valid && (int'(flush_warp) == m_req_warp);
    found = 0; g = 0;
    for (int k = 1; k <= W; k++) begin
      w = (m_ptr + k) % W;
      if (!found && m_active[w] && pif.valid[w] && !m_pending[w]
          && !(flush_valid && int'(flush_warp) == w)) begin
        found = 1; g = w;
      end
    end
    if (withdraw) m_req_valid = 0;
    else if (can_issue) begin
      m_req_valid = found;
      if (found) begin
        m_req_warp = g; m_req_pc = pif.pc[g]; m_req_epoch = m_epoch[g];
        m_slot_pc[g] = pif.pc[g]; m_slot_sp[g] = pif.split_table_num[g];
        m_pending[g] = 1; m_active[g] = 0; m_ptr = g;
      end
    end
    if (hit) m_pending[rsp_warp] = 0;
    if (pif.activate_valid) m_active[pif.activate_warp_num] = 1;
    if (flush_valid) begin
      m_epoch[flush_warp] = !m_epoch[flush_warp];
      m_pending[flush_warp] = 0;
      m_active[flush_warp] = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic activate(input int w);
    pif.activate_valid = 1'b1;
    pif.activate_warp_num = warp_num_t'(w);
  endtask

  task automatic respond(input int w, input bit ep, input logic [31:0] inst);
    rsp_valid = 1'b1; rsp_warp = warp_num_t'(w); rsp_epoch = ep; rsp_inst = inst;
  endtask

  initial begin
    rsp_from_q = 1'b0;
    // Single activation -> single request one cycle later
    do_reset();
    pif.valid[3] = 1'b1; pif.pc[3] = 32'h100;
    activate(3); step();
    idle(); step();
    check("t1_req_valid", 64'(req_valid), 64'd1);
    check("t1_req_pc",    64'(req_pc),    64'h100);
    check("t1_req_warp",  64'(req_warp),  64'd3);
    check("t1_req_epoch", 64'(req_epoch), 64'd0);
    step(); step(); step();
    check("t1_no_refetch", 64'(req_valid), 64'd0);

    // Round-robin order from ptr = 0
    do_reset();
    pif.valid[0] = 1'b1;
    req_ready = 1'b0; activate(0); step();
    req_ready = 1'b1; activate(1); step();
    activate(2); step();
    idle(); activate(0); respond(0, 1'b0, 32'h1111_0000); step();
    idle();
    for (int w = 0; w < 3; w++) pif.valid[w] = 1'b1;
    step(); check("t2_grant_a", 64'(req_warp), 64'd1);
    step(); check("t2_grant_b", 64'(req_warp), 64'd2);
    step(); check("t2_grant_c", 64'(req_warp), 64'd0);

    // Back-pressure: request held for five cycles
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_valid", 64'(req_valid), 64'd1);
      check("t3_hold_warp",  64'(req_warp),  64'd0);
      check("t3_hold_pc",    64'(req_pc),    64'h1000);
    end
`ifdef GELATO_FETCH_PERF_EN
    check("t3_perf_stall", 64'(perf_stall_cnt), 64'd5);
`endif

    // Output held under out_ready = 0, second response back-pressured
    out_ready = 1'b0; respond(1, 1'b0, 32'hDEAD_BEEF); step();
    check("t4_out_warp", 64'(out_warp), 64'd1);
    check("t4_out_pc",   64'(out_pc),   64'h1010);
    check("t4_out_inst", 64'(out_inst), 64'hDEAD_BEEF);
    respond(2, 1'b0, 32'hCAFE_F00D); step();
    check("t4_hold_inst", 64'(out_inst), 64'hDEAD_BEEF);
    out_ready = 1'b1; step();
    check("t4_next_inst", 64'(out_inst), 64'hCAFE_F00D);
    idle(); step();
    check("t4_drained", 64'(out_valid), 64'd0);

    // Flush drops the stale response; re-fetch carries the new epoch
    req_ready = 1'b1; activate(2); step();
    idle(); step();
    check("t5_req_warp",  64'(req_warp),  64'd2);
    check("t5_req_epoch", 64'(req_epoch), 64'd0);
    step();
    flush_valid = 1'b1; flush_warp = warp_num_t'(2); step();
    idle(); respond(2, 1'b0, 32'h5555_AAAA); step();
    check("t5_dropped", 64'(out_valid), 64'd0);
`ifdef GELATO_FETCH_PERF_EN
    check("t5_perf_drop", 64'(perf_drop_cnt), 64'd1);
`endif
    idle(); activate(2); step();
    idle(); step();
    check("t5_refetch_valid", 64'(req_valid), 64'd1);
    check("t5_refetch_warp",  64'(req_warp),  64'd2);
    check("t5_refetch_epoch", 64'(req_epoch), 64'd1);

    // Same-cycle activate and grant keeps the warp active
    do_reset();
    pif.valid[5] = 1'b1;
    activate(5); step();
    step();
    check("t6_req_warp", 64'(req_warp), 64'd5);
    idle(); step(); step(); step();
    check("t6_blocked", 64'(req_valid), 64'd0);
    respond(5, 1'b0, 32'h0000_0555); step();
    idle(); step();
    check("t6_regrant_valid", 64'(req_valid), 64'd1);
    check("t6_regrant_warp",  64'(req_warp),  64'd5);

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int w = 0; w < W; w++) begin
        pif.valid[w] = ($urandom_range(0, 3) != 0);
        pif.pc[w] = $urandom() & 32'hFFFF_FFFC;
        pif.split_table_num[w] = 4'($urandom_range(0, 15));
      end
      pif.activate_valid = ($urandom_range(0, 1) != 0);
      pif.activate_warp_num = warp_num_t'($urandom_range(0, W - 1));
      req_ready = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush_valid = ($urandom_range(0, 19) == 0);
      flush_warp = warp_num_t'($urandom_range(0, W - 1));
      rsp_inst = $urandom();
      if ($urandom_range(0, 9) == 0) begin
        rsp_valid = 1'b1; rsp_from_q = 1'b0;
        rsp_warp = warp_num_t'($urandom_range(0, W - 1));
        rsp_epoch = ($urandom_range(0, 1) != 0);
      end else if (icq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rsp_valid = 1'b1; rsp_from_q = 1'b1;
        rsp_warp = warp_num_t'(icq[0].warp);
        rsp_epoch = icq[0].epoch ^ ($urandom_range(0, 15) == 0);
      end else begin
        rsp_valid = 1'b0; rsp_from_q = 1'b0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
